// File: rtl/fade_apply.sv
// Fader controller: schedules fader requests, double-buffers each 32-word coefficient
// burst and applies the active complex coefficient to a channel-tagged sample stream.
module fade_apply #(
  parameter int unsigned N             = 32,
  parameter int unsigned WCHAN         = 5,
  parameter int unsigned UPDATE_PERIOD = 1024,
  parameter int unsigned SHIFT         = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    fade_start,
  output logic [24:0]             fade_t_index,
  input  logic                    fade_dv,
  input  logic [WCHAN-1:0]        fade_chan,
  input  logic signed [15:0]      fade_imag,
  input  logic signed [15:0]      fade_real,
  input  logic                    s_valid,
  input  logic [WCHAN-1:0]        s_chan,
  input  logic signed [15:0]      s_real,
  input  logic signed [15:0]      s_imag,
  output logic                    m_valid,
  output logic [WCHAN-1:0]        m_chan,
  output logic signed [15:0]      m_real,
  output logic signed [15:0]      m_imag,
  output logic                    bank_swap,
  output logic                    burst_err
);

  localparam int unsigned     WPER     = $clog2(UPDATE_PERIOD);
  localparam logic [WPER-1:0] PER_LAST = WPER'(UPDATE_PERIOD - 1);
  localparam int unsigned     WCNT     = WCHAN + 1;
  localparam logic [WCNT-1:0] CNT_FULL = WCNT'(N - 1);

  // ---------------- scheduler ----------------
  logic [WPER-1:0] per_cnt;
  logic [24:0]     t_count;

  // fade_start/fade_t_index are registered one cycle ahead so they are high while per_cnt == 0
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt      <= PER_LAST;
      t_count      <= '0;
      fade_start   <= 1'b0;
      fade_t_index <= '0;
    end else begin
      per_cnt    <= (per_cnt == '0) ? PER_LAST : per_cnt - 1'b1;
      fade_start <= (per_cnt == WPER'(1));
      if (per_cnt == WPER'(1)) begin
        fade_t_index <= t_count;
        t_count      <= t_count + 1'b1;
      end
    end
  end

  // ---------------- coefficient capture ----------------
  logic [31:0]     bank [2][N];
  logic            sel;
  logic            coef_valid;
  logic [WCNT-1:0] cap_cnt;

  always_ff @(posedge clk) begin
    if (fade_dv && !fade_start)
      bank[!sel][fade_chan] <= {fade_real, fade_imag};
  end

  // Select flips on the same edge that raises bank_swap, so the swap cycle already reads the new bank
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_cnt    <= '0;
      sel        <= 1'b0;
      coef_valid <= 1'b0;
      bank_swap  <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      bank_swap <= 1'b0;
      if (fade_start) begin
        if (fade_dv || cap_cnt != '0)
          burst_err <= 1'b1;
        cap_cnt <= '0;
      end else if (fade_dv) begin
        if (fade_chan == '0) begin
          cap_cnt <= '0;
          if (cap_cnt == CNT_FULL) begin
            bank_swap  <= 1'b1;
            sel        <= ~sel;
            coef_valid <= 1'b1;
          end else begin
            burst_err <= 1'b1;
          end
        end else if (cap_cnt != '1) begin
          cap_cnt <= cap_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- apply pipeline ----------------
  logic                   v1, v2, v3;
  logic [WCHAN-1:0]       ch1, ch2, ch3;
  logic signed [15:0]     sr1, si1, cr1, ci1;
  logic signed [31:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0]     re_sum, im_sum;
  logic signed [32:0]     sh_re, sh_im;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767)
      return 16'sh7fff;
    else if (x < -33'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  always_comb begin
    re_sum = $signed({p_rr[31], p_rr}) - $signed({p_ii[31], p_ii});
    im_sum = $signed({p_ri[31], p_ri}) + $signed({p_ir[31], p_ir});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= s_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    ch1 <= s_chan;
    sr1 <= s_real;
    si1 <= s_imag;
    {cr1, ci1} <= coef_valid ? bank[sel][s_chan] : '0;
    ch2  <= ch1;
    p_rr <= sr1 * cr1;
    p_ii <= si1 * ci1;
    p_ri <= sr1 * ci1;
    p_ir <= si1 * cr1;
    ch3   <= ch2;
    sh_re <= re_sum >>> SHIFT;
    sh_im <= im_sum >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_chan  <= '0;
      m_real  <= '0;
      m_imag  <= '0;
    end else begin
      m_valid <= v3;
      if (v3) begin
        m_chan <= ch3;
        m_real <= sat16(sh_re);
        m_imag <= sat16(sh_im);
      end
    end
  end

endmodule

// File: tb/tb_fade_apply.sv
// Directed bench for fade_apply: scheduler timing, burst capture/swap, complex scaling,
// saturation, burst error handling and reset behaviour.
module tb_fade_apply;

  logic               clk = 1'b0;
  logic               reset;
  logic               fade_start;
  logic [24:0]        fade_t_index;
  logic               fade_dv;
  logic [4:0]         fade_chan;
  logic signed [15:0] fade_imag, fade_real;
  logic               s_valid;
  logic [4:0]         s_chan;
  logic signed [15:0] s_real, s_imag;
  logic               m_valid;
  logic [4:0]         m_chan;
  logic signed [15:0] m_real, m_imag;
  logic               bank_swap, burst_err;

  int checks = 0;
  int errors = 0;

  fade_apply #(.UPDATE_PERIOD(300)) dut (
    .clk(clk), .reset(reset),
    .fade_start(fade_start), .fade_t_index(fade_t_index),
    .fade_dv(fade_dv), .fade_chan(fade_chan), .fade_imag(fade_imag), .fade_real(fade_real),
    .s_valid(s_valid), .s_chan(s_chan), .s_real(s_real), .s_imag(s_imag),
    .m_valid(m_valid), .m_chan(m_chan), .m_real(m_real), .m_imag(m_imag),
    .bank_swap(bank_swap), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; fade_dv = 1'b0; fade_chan = '0; fade_real = '0; fade_imag = '0;
    s_valid = 1'b0; s_chan = '0; s_real = '0; s_imag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fade_start, fade_t_index, m_valid, m_chan, m_real, m_imag, bank_swap, burst_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: fs=%b ti=%0d mv=%b mc=%0d mr=%0d mi=%0d bs=%b be=%b, all required 0",
               fade_start, fade_t_index, m_valid, m_chan, m_real, m_imag, bank_swap, burst_err);
    end
    reset = 1'b0;
  endtask

  // Cycle 1 is the negedge at which reset is released
  task automatic test_scheduler();
    logic        exp_s;
    logic [24:0] exp_t;
    for (int c = 1; c <= 905; c++) begin
      if (c > 1) @(negedge clk);
      exp_s = (c % 300 == 0);
      exp_t = (c < 300) ? 25'd0 : 25'(c / 300 - 1);
      checks++;
      if (fade_start !== exp_s) begin
        errors++;
        $display("FAIL sched_start c=%0d: got %b required %b", c, fade_start, exp_s);
      end
      checks++;
      if (fade_t_index !== exp_t) begin
        errors++;
        $display("FAIL sched_tindex c=%0d: got %0d required %0d", c, fade_t_index, exp_t);
      end
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (fade_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fade_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_start: no fade_start within 400 cycles, got %b required 1", fade_start);
    end
  endtask

  // Burst of nwords words, chan 31 downward; ends at the negedge of the cycle after the last word
  task automatic send_burst(input int nwords, input logic [4:0] sp_ch,
                            input logic signed [15:0] sp_r, input logic signed [15:0] sp_i,
                            input logic signed [15:0] dr, input logic signed [15:0] di);
    for (int k = 0; k < nwords; k++) begin
      @(negedge clk);
      fade_dv   = 1'b1;
      fade_chan = 5'(31 - k);
      fade_real = (fade_chan == sp_ch) ? sp_r : dr;
      fade_imag = (fade_chan == sp_ch) ? sp_i : di;
    end
    @(negedge clk);
    fade_dv = 1'b0;
    checks++;
    if (bank_swap !== (nwords == 32)) begin
      errors++;
      $display("FAIL bank_swap_after_burst(%0d words): got %b required %b", nwords, bank_swap, nwords == 32);
    end
  endtask

  task automatic send_sample(input logic [4:0] ch, input logic signed [15:0] sr, input logic signed [15:0] si,
                             input logic signed [15:0] er, input logic signed [15:0] ei, input string name);
    s_valid = 1'b1; s_chan = ch; s_real = sr; s_imag = si;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        s_valid = 1'b0; s_real = '0; s_imag = '0; s_chan = '0;
      end
      if (i < 4) begin
        checks++;
        if (m_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s_latency: m_valid=%b at +%0d, required 0", name, m_valid, i);
        end
      end
    end
    checks++;
    if (m_valid !== 1'b1 || m_chan !== ch || m_real !== er || m_imag !== ei) begin
      errors++;
      $display("FAIL %s: got v=%b ch=%0d (%0d,%0d) required v=1 ch=%0d (%0d,%0d)",
               name, m_valid, m_chan, m_real, m_imag, ch, er, ei);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_chan !== ch || m_real !== er || m_imag !== ei) begin
      errors++;
      $display("FAIL %s_hold: got v=%b ch=%0d (%0d,%0d) required v=0 ch=%0d (%0d,%0d)",
               name, m_valid, m_chan, m_real, m_imag, ch, er, ei);
    end
  endtask

  task automatic test_no_coef();
    send_sample(5'd3, 16'sd1000, 16'sd2000, 16'sd0, 16'sd0, "no_coef");
  endtask

  task automatic test_unity();
    wait_start();
    send_burst(32, 5'd0, 16'sd8192, 16'sd0, 16'sd8192, 16'sd0);
    @(negedge clk);
    checks++;
    if (bank_swap !== 1'b0) begin
      errors++;
      $display("FAIL bank_swap_width: got %b required 0", bank_swap);
    end
    send_sample(5'd5, 16'sd1000, -16'sd2000, 16'sd1000, -16'sd2000, "unity");
  endtask

  task automatic test_rotate();
    wait_start();
    send_burst(32, 5'd7, 16'sd0, 16'sd8192, 16'sd8192, 16'sd0);
    send_sample(5'd7, 16'sd1000, 16'sd2000, -16'sd2000, 16'sd1000, "rotate_swap_cycle");
    send_sample(5'd6, 16'sd300, -16'sd400, 16'sd300, -16'sd400, "rotate_other_chan");
  endtask

  task automatic test_saturate();
    wait_start();
    send_burst(32, 5'd2, 16'sd32767, 16'sd0, 16'sd8192, 16'sd0);
    send_sample(5'd2, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0, "sat_pos");
    send_sample(5'd2, -16'sd32768, 16'sd0, -16'sd32768, 16'sd0, "sat_neg");
  endtask

  task automatic test_floor_shift();
    wait_start();
    send_burst(32, 5'd4, 16'sd4096, 16'sd0, 16'sd8192, 16'sd0);
    send_sample(5'd4, -16'sd3, 16'sd3, -16'sd2, 16'sd1, "floor_shift");
  endtask

  task automatic test_back_to_back();
    logic [4:0]         ch [3];
    logic signed [15:0] sr [3], si [3], er [3], ei [3];
    ch = '{5'd4, 5'd9, 5'd4};
    sr = '{16'sd100, -16'sd5, -16'sd8};  si = '{-16'sd100, 16'sd7, 16'sd8};
    er = '{16'sd50, -16'sd5, -16'sd4};   ei = '{-16'sd50, 16'sd7, 16'sd4};
    for (int k = 0; k < 7; k++) begin
      if (k >= 4) begin
        checks++;
        if (m_valid !== 1'b1 || m_chan !== ch[k-4] || m_real !== er[k-4] || m_imag !== ei[k-4]) begin
          errors++;
          $display("FAIL b2b[%0d]: got v=%b ch=%0d (%0d,%0d) required v=1 ch=%0d (%0d,%0d)",
                   k - 4, m_valid, m_chan, m_real, m_imag, ch[k-4], er[k-4], ei[k-4]);
        end
      end
      if (k < 3) begin
        s_valid = 1'b1; s_chan = ch[k]; s_real = sr[k]; s_imag = si[k];
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_burst_err();
    wait_start();
    send_burst(20, 5'd20, 16'sd0, 16'sd8192, 16'sd0, 16'sd8192);
    wait_start();
    checks++;
    if (burst_err !== 1'b0) begin
      errors++;
      $display("FAIL err_early: got %b required 0", burst_err);
    end
    @(negedge clk);
    checks++;
    if (burst_err !== 1'b1 || bank_swap !== 1'b0) begin
      errors++;
      $display("FAIL err_partial: got err=%b swap=%b required err=1 swap=0", burst_err, bank_swap);
    end
    send_sample(5'd20, 16'sd1000, 16'sd2000, 16'sd1000, 16'sd2000, "err_old_bank");
    send_burst(32, 5'd20, -16'sd8192, 16'sd0, 16'sd8192, 16'sd0);
    @(negedge clk);
    checks++;
    if (burst_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", burst_err);
    end
    send_sample(5'd20, 16'sd1000, 16'sd2000, -16'sd1000, -16'sd2000, "err_new_bank");
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1; s_chan = 5'd1; s_real = 16'sd123; s_imag = 16'sd456;
    repeat (4) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_real !== 16'sd123 || m_imag !== 16'sd456) begin
      errors++;
      $display("FAIL stream_before_reset: got v=%b (%0d,%0d) required v=1 (123,456)", m_valid, m_real, m_imag);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({fade_start, fade_t_index, m_valid, m_chan, m_real, m_imag, bank_swap, burst_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: fs=%b ti=%0d mv=%b mc=%0d mr=%0d mi=%0d bs=%b be=%b, all required 0",
               fade_start, fade_t_index, m_valid, m_chan, m_real, m_imag, bank_swap, burst_err);
    end
    reset = 1'b0;
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after_reset: m_valid=%b required 0", m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_scheduler();
    test_no_coef();
    test_unity();
    test_rotate();
    test_saturate();
    test_floor_shift();
    test_back_to_back();
    test_burst_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
